fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request to the instruction cache.
REQ-005 SHALL have port imem_addr  output  32  fetch address; held stable while imem_req=1 and imem_ready=0.
REQ-006 SHALL have port imem_ready  input  1  cache returns a word this cycle (same-cycle on hit, later on miss).
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-008 SHALL have port stall_d  input  1  from the hazard unit: decode cannot accept a new instruction.
REQ-009 SHALL have port flush_d  input  1  kill the instruction in the decode register.
REQ-010 SHALL have ports redirect  input  1 and redirect_pc  input  32: taken branch/jal/jalr target from execute.
REQ-011 SHALL have ports instr_d  output  32, pc_d  output  32, pcplus4_d  output  32 and valid_d  output  1, forming the decode register that feeds the main decoder.

Function
REQ-012 SHALL implement the states FETCH, WAIT and DISCARD.
REQ-013 FETCH: imem_req=1, imem_addr=pc; imem_ready=0 -> WAIT; imem_ready=1 -> the word is accepted as in REQ-015.
REQ-014 WAIT: hold imem_req=1 and imem_addr until imem_ready=1, then accept the word and return to FETCH.
REQ-015 Accepting a word with stall_d=0 SHALL load instr_d=imem_rdata, pc_d=pc, pcplus4_d=pc+4 and valid_d=1, and set pc to pc+4 (mod 2^32, wrapping at 32'hFFFF_FFFC).
REQ-016 Accepting a word with stall_d=1 SHALL write it, with its pc, into a one-entry skid buffer, hold the decode register and pc, and force imem_req=0 while the skid is full.
REQ-017 When stall_d falls with the skid full, the skid contents SHALL move into the decode register on that edge, and fetching SHALL resume the next cycle; decode-to-decode latency is 1 cycle.
REQ-018 redirect=1 SHALL clear the decode register and skid, and set pc to redirect_pc; the next FETCH presents redirect_pc.
REQ-019 redirect=1 in WAIT SHALL go to DISCARD: keep the old request until imem_ready=1, drop that word, then fetch the latched redirect_pc.
REQ-020 flush_d=1 SHALL clear the decode register to instr_d=0, pc_d=0, pcplus4_d=0 and valid_d=0 (opcode 0 decodes as no-op).
REQ-021 Priority SHALL be: redirect > flush_d > stall_d; flush_d with stall_d=1 still clears decode.
REQ-022 Whenever valid_d=0, instr_d SHALL be 32'h0.
REQ-023 A second redirect in DISCARD SHALL overwrite the latched target; the last one wins.

Reset
REQ-024 rst_n=0 SHALL immediately set state=FETCH, pc=RESET_PC, skid empty, and instr_d=0, pc_d=0, pcplus4_d=0, valid_d=0.
REQ-025 imem_req SHALL be 0 while rst_n=0, and 1 in the first cycle after release.
REQ-026 Reset during WAIT or DISCARD SHALL abandon the outstanding request; the cache handles the abandoned request itself.

Configuration
REQ-027 With FETCH_PERF_EN defined, the block SHALL add port stall_cycles  output  32: a counter that resets to 0 and increments each cycle state is WAIT or DISCARD, or the skid is full; it saturates at 32'hFFFF_FFFF.
REQ-028 Without FETCH_PERF_EN, the port and counter SHALL be absent, and the remaining behaviour SHALL be unchanged.

Structure
REQ-029 The fetch_state_t enum and the NOP_INSTR constant (32'h0) SHALL be placed in the shared package fetch_pkg.
REQ-030 The skid buffer SHALL be the sub-module fetch_skid, with one entry of instr and pc plus a full flag; everything else stays inline.

Verification
REQ-031 Reset release with RESET_PC=0, always-hit cache -> imem_addr 0,4,8 on cycles 1,2,3; valid_d=1 from cycle 2.
REQ-032 Miss at 0x8 with imem_ready low for 3 cycles -> imem_addr held at 0x8 for 4 cycles; instr_d updates once; pc_d=0x8.
REQ-033 stall_d=1 for 2 cycles while a hit returns 0x00500093 -> word is held in the skid, imem_req=0, decode is held; it appears in instr_d on the cycle after stall_d falls.
REQ-034 redirect to 0x100 in WAIT -> the old word is dropped; the next imem_addr is 0x100; valid_d=0 until the 0x100 word is accepted.
REQ-035 flush_d and stall_d asserted together -> instr_d=0 and valid_d=0 on the next edge.
REQ-036 FETCH_PERF_EN defined, 3-cycle miss -> stall_cycles increments by 3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } decode_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            rd_en,
  input  logic            clr,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  fetch_entry_t entry_q;

  // Clear has priority: a redirect discards whatever was parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      entry_q <= '0;
    end else if (clr) begin
      full    <= 1'b0;
      entry_q <= '0;
    end else if (wr_en) begin
      full    <= 1'b1;
      entry_q <= '{instr: wr_instr, pc: wr_pc};
    end else if (rd_en) begin
      full    <= 1'b0;
    end
  end

  assign instr = entry_q.instr;
  assign pc    = entry_q.pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, cache handshake, skid buffer and decode register.
// Optional FETCH_PERF_EN adds the stall_cycles performance counter port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  fetch_state_t    state_q, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] tgt_q, tgt_nxt;
  decode_t         dec_q, dec_nxt;

  logic            skid_wr, skid_rd, skid_clr, skid_full;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            accept;

  // No request while a word is parked; reset gates the request off immediately.
  assign imem_req  = rst_n & ~skid_full;
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready & (state_q != DISCARD);

  fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (skid_wr),
    .wr_instr (imem_rdata),
    .wr_pc    (pc_q),
    .rd_en    (skid_rd),
    .clr      (skid_clr),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      dec_q   <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      tgt_q   <= tgt_nxt;
      dec_q   <= dec_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    tgt_nxt   = tgt_q;
    dec_nxt   = dec_q;
    skid_wr   = 1'b0;
    skid_rd   = 1'b0;
    skid_clr  = 1'b0;

    // An unanswered request is never abandoned, so redirects during one go to DISCARD.
    unique case (state_q)
      FETCH: begin
        if (imem_req && !imem_ready) state_nxt = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (imem_ready)    state_nxt = FETCH;
        else if (redirect) state_nxt = DISCARD;
      end
      DISCARD: begin
        if (imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    if (redirect) begin
      skid_clr = 1'b1;
      dec_nxt  = '0;
      if (state_nxt == DISCARD) tgt_nxt = redirect_pc;
      else                      pc_nxt  = redirect_pc;
    end else begin
      if (state_q == DISCARD && imem_ready) pc_nxt = tgt_q;
      if (accept) pc_nxt = pc_plus4(pc_q);

      // A word that decode cannot take this edge is parked in the skid.
      if (flush_d) begin
        dec_nxt = '0;
        skid_wr = accept;
      end else if (stall_d) begin
        skid_wr = accept;
      end else if (skid_full) begin
        dec_nxt = '{instr: skid_instr, pc: skid_pc, pcplus4: pc_plus4(skid_pc), valid: 1'b1};
        skid_rd = 1'b1;
      end else if (accept) begin
        dec_nxt = '{instr: imem_rdata, pc: pc_q, pcplus4: pc_plus4(pc_q), valid: 1'b1};
      end
    end

    if (!dec_nxt.valid) dec_nxt.instr = NOP_INSTR;
  end

  assign instr_d   = dec_q.instr;
  assign pc_d      = dec_q.pc;
  assign pcplus4_d = dec_q.pcplus4;
  assign valid_d   = dec_q.valid;

`ifdef FETCH_PERF_EN
  logic stall_cycle;
  assign stall_cycle = (state_q == WAIT) || (state_q == DISCARD) || skid_full;

  // Saturating count of cycles spent waiting on the cache or holding a parked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cycles <= '0;
    else if (stall_cycle && stall_cycles != '1) stall_cycles <= stall_cycles + XLEN'(1);
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected decode entries, a monitor pops them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pcplus4_d   (pcplus4_d),
    .valid_d     (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Cache model: every address returns a recognisable word.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {16'hC0DE, a[15:0]};
  endfunction
  assign imem_rdata = word_of(imem_addr);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
    sb.push_back('{instr: i, pc: p, pcplus4: p4});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every newly presented valid decode entry must match the head of the scoreboard.
  logic [63:0] last_seen = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_d === 1'b1 && {pc_d, instr_d} != last_seen) begin
      if (sb.size() == 0) begin
        chk("unexpected_decode_pc", pc_d, 32'hDEAD_DEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr_d", instr_d, e.instr);
        chk("sb_pc_d", pc_d, e.pc);
        chk("sb_pcplus4_d", pcplus4_d, e.pcplus4);
      end
    end
    last_seen = {pc_d, instr_d};
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_valid_d", 32'(valid_d), 32'd0);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pcplus4_d", pcplus4_d, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
    #8 rst_n = 1'b1;
    #1;
    chk("c1_imem_req", 32'(imem_req), 32'd1);
    chk("c1_imem_addr", imem_addr, 32'h0);
    push(32'hC0DE_0000, 32'h0, 32'h4);
    step();
    chk("c2_imem_addr", imem_addr, 32'h4);
    chk("c2_valid_d", 32'(valid_d), 32'd1);
    push(32'hC0DE_0004, 32'h4, 32'h8);
    step();
    chk("c3_imem_addr", imem_addr, 32'h8);
    push(32'hC0DE_0008, 32'h8, 32'hC);
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("miss_addr_hold", imem_addr, 32'h8);
      chk("miss_req_hold", 32'(imem_req), 32'd1);
      chk("miss_pc_d_hold", pc_d, 32'h4);
    end
    imem_ready = 1'b1;
    step();
    chk("miss_done_addr", imem_addr, 32'hC);
    chk("miss_done_pc_d", pc_d, 32'h8);
`ifdef FETCH_PERF_EN
    chk("perf_miss_count", stall_cycles, 32'd3);
`endif
    push(32'hC0DE_000C, 32'hC, 32'h10);
    step();
    chk("skid_pre_addr", imem_addr, 32'h10);
    push(32'h0050_0093, 32'h10, 32'h14);
    stall_d = 1'b1;
    step();
    chk("skid_req_low1", 32'(imem_req), 32'd0);
    chk("skid_hold_pc_d1", pc_d, 32'hC);
    step();
    chk("skid_req_low2", 32'(imem_req), 32'd0);
    chk("skid_hold_instr_d2", instr_d, 32'hC0DE_000C);
    stall_d = 1'b0;
    step();
    chk("skid_out_instr_d", instr_d, 32'h0050_0093);
    chk("skid_out_req", 32'(imem_req), 32'd1);
    chk("skid_out_addr", imem_addr, 32'h14);
    imem_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("disc_addr_old", imem_addr, 32'h14);
    chk("disc_req", 32'(imem_req), 32'd1);
    chk("disc_valid_d", 32'(valid_d), 32'd0);
    chk("disc_instr_d", instr_d, 32'h0);
    imem_ready = 1'b1;
    step();
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid_d", 32'(valid_d), 32'd0);
    push(32'hC0DE_0100, 32'h100, 32'h104);
    step();
    chk("redir_next_addr", imem_addr, 32'h104);
    push(32'hC0DE_0104, 32'h104, 32'h108);
    flush_d = 1'b1; stall_d = 1'b1;
    step();
    chk("flush_instr_d", instr_d, 32'h0);
    chk("flush_valid_d", 32'(valid_d), 32'd0);
    chk("flush_pc_d", pc_d, 32'h0);
    flush_d = 1'b0; stall_d = 1'b0;
    step();
    chk("post_flush_addr", imem_addr, 32'h108);
    chk("post_flush_pc_d", pc_d, 32'h104);
    push(32'hC0DE_0108, 32'h108, 32'h10C);
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_valid_d", 32'(valid_d), 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    push(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0);
    step();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_pcplus4_d", pcplus4_d, 32'h0);
    push(32'hC0DE_0000, 32'h0, 32'h4);
    step();
    imem_ready = 1'b0;
    chk("wrap_after_addr", imem_addr, 32'h4);
    step(); step(); step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
